// File: rtl/fifo_tx_sequencer_pkg.sv
// fifo_tx_sequencer_pkg
//   Shared definitions for the FIFO -> UART TX sequencer:
//   - default word width
//   - 3-bit state encoding of the sequencer FSM
//   - small helper for sizing the shared timer
package fifo_tx_sequencer_pkg;

  localparam int DEF_WORD_LEN = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_POP   = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_START = 3'd3;
  localparam logic [2:0] ST_ACK   = 3'd4;
  localparam logic [2:0] ST_DRAIN = 3'd5;
  localparam logic [2:0] ST_GAP   = 3'd6;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    POP   = ST_POP,
    LOAD  = ST_LOAD,
    START = ST_START,
    ACK   = ST_ACK,
    DRAIN = ST_DRAIN,
    GAP   = ST_GAP
  } seq_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fifo_tx_sequencer_timer.sv
// cycle_timer
//   Loadable down-counter shared by the ACK timeout and the inter-character gap.
//   Ports:
//     clk, rst       clock, synchronous active-high reset
//     load, load_val load the counter (load has priority over dec)
//     dec            decrement by one; saturates at zero
//     cnt            current count
//     zero           cnt == 0
module cycle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (rst)                  cnt <= '0;
    else if (load)            cnt <= load_val;
    else if (dec && cnt != 0) cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/fifo_tx_sequencer.sv
// fifo_tx_sequencer
//   Drains a byte FIFO into a UART transmitter: pops one word whenever the
//   FIFO is non-empty, the transmitter idle and transfers enabled, strobes
//   tx_start, waits for the character to finish, then optionally idles for
//   GAP_CYCLES clocks. A missing busy acknowledge sets a sticky error.
//   Ports:
//     clk, rst              clock, synchronous active-high reset
//     en                    permit new transfers (looked at only in IDLE)
//     fifo_empty, fifo_out  FIFO status / registered read data
//     fifo_re               FIFO read strobe, one cycle per word
//     tx_busy               transmitter busy
//     tx_start, tx_data     start strobe and character to the transmitter
//     active                sequencer not idle
//     sent_count            completed characters (wraps)
//     err, err_clr          sticky ACK-timeout flag and its clear
module fifo_tx_sequencer
  import fifo_tx_sequencer_pkg::*;
#(
  parameter int WORD_LEN    = DEF_WORD_LEN,
  parameter int GAP_CYCLES  = 0,
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                fifo_empty,
  input  logic [WORD_LEN-1:0] fifo_out,
  output logic                fifo_re,
  input  logic                tx_busy,
  output logic                tx_start,
  output logic [WORD_LEN-1:0] tx_data,
  output logic                active,
  output logic [15:0]         sent_count,
  output logic                err,
  input  logic                err_clr
);

  localparam int TW = $clog2(max2(ACK_TIMEOUT, GAP_CYCLES) + 1);

  seq_state_t          state;
  logic [WORD_LEN-1:0] data_q;
  logic                load_q;   // high while in LOAD: fifo_out is the live word

  logic          tmr_load, tmr_dec, tmr_zero;
  logic [TW-1:0] tmr_val, tmr_cnt;

  // Timer is loaded on the way into ACK and on the way into GAP; it counts
  // down while waiting for busy and while idling in GAP.
  always_comb begin
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = '0;
    case (state)
      START: begin
        tmr_load = 1'b1;
        tmr_val  = TW'(ACK_TIMEOUT);
      end
      ACK:   tmr_dec = !tx_busy;
      DRAIN: begin
        tmr_load = !tx_busy;
        tmr_val  = (GAP_CYCLES > 0) ? TW'(GAP_CYCLES - 1) : '0;
      end
      GAP:   tmr_dec = 1'b1;
      default: ;
    endcase
  end

  cycle_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .cnt      (tmr_cnt),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      fifo_re    <= 1'b0;
      tx_start   <= 1'b0;
      data_q     <= '0;
      load_q     <= 1'b0;
      active     <= 1'b0;
      sent_count <= '0;
      err        <= 1'b0;
    end else begin
      fifo_re  <= 1'b0;
      tx_start <= 1'b0;
      load_q   <= 1'b0;
      // A timeout in the same cycle overrides this below.
      if (err_clr) err <= 1'b0;
      case (state)
        IDLE: begin
          if (en && !fifo_empty && !tx_busy) begin
            state   <= POP;
            fifo_re <= 1'b1;
            active  <= 1'b1;
          end
        end
        POP: begin
          state  <= LOAD;
          load_q <= 1'b1;
        end
        LOAD: begin
          data_q   <= fifo_out;
          state    <= START;
          tx_start <= 1'b1;
        end
        START: state <= ACK;
        ACK: begin
          if (tx_busy) begin
            state <= DRAIN;
          end else if (tmr_cnt == TW'(1)) begin
            // Last wait cycle expires: drop the character.
            err    <= 1'b1;
            state  <= IDLE;
            active <= 1'b0;
          end
        end
        DRAIN: begin
          if (!tx_busy) begin
            sent_count <= sent_count + 16'd1;
            if (GAP_CYCLES > 0) begin
              state <= GAP;
            end else begin
              state  <= IDLE;
              active <= 1'b0;
            end
          end
        end
        GAP: begin
          if (tmr_zero) begin
            state  <= IDLE;
            active <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          active <= 1'b0;
        end
      endcase
    end
  end

  // Word is visible straight from the FIFO during LOAD, then held in data_q.
  assign tx_data = load_q ? fifo_out : data_q;

endmodule

// File: tb/tb_fifo_tx_sequencer.sv
module tb_fifo_tx_sequencer;
  localparam int WL  = 8;
  localparam int GAP = 3;
  localparam int ATO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          fifo_empty;
  logic [WL-1:0] fifo_out = '0;
  logic          fifo_re;
  logic          tx_busy;
  logic          tx_start;
  logic [WL-1:0] tx_data;
  logic          active;
  logic [15:0]   sent_count;
  logic          err;
  logic          err_clr = 1'b0;

  always #5 clk = ~clk;

  fifo_tx_sequencer #(.WORD_LEN(WL), .GAP_CYCLES(GAP), .ACK_TIMEOUT(ATO)) dut (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_out(fifo_out),
    .fifo_re(fifo_re), .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .active(active), .sent_count(sent_count), .err(err), .err_clr(err_clr)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // FIFO model: registered read data, valid the cycle after fifo_re
  logic [WL-1:0] mem [256];
  logic [7:0]    wr_ptr = '0;
  logic [7:0]    rd_ptr = '0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_re) begin
      fifo_out <= mem[rd_ptr];
      rd_ptr   <= rd_ptr + 8'd1;
    end
  end

  logic [WL-1:0] exp_q [$];

  task automatic push(input logic [WL-1:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 8'd1;
    exp_q.push_back(w);
  endtask

  // Transmitter model: busy rises d cycles after tx_start and holds b cycles
  logic busy_auto = 1'b0;
  logic busy_man  = 1'b0;
  int   tx_mode   = 0;   // 0 = respond, 1 = never respond
  int   fix_d     = 0;
  int   fix_b     = 0;
  assign tx_busy = busy_auto | busy_man;

  initial begin
    forever begin
      @(negedge clk);
      if (tx_start && tx_mode == 0) begin
        int d, b;
        d = (fix_d != 0) ? fix_d : int'($urandom_range(1, 3));
        b = (fix_b != 0) ? fix_b : int'($urandom_range(1, 6));
        repeat (d) @(posedge clk);
        #1 busy_auto = 1'b1;
        repeat (b) @(posedge clk);
        #1 busy_auto = 1'b0;
      end
    end
  end

  // Monitor: protocol rules checked every cycle, mid-cycle
  int            cyc = 0;
  int            n_re = 0;
  int            n_start = 0;
  logic          cond_prev = 1'b0;
  logic          re_d1 = 1'b0, re_d2 = 1'b0;
  logic          rst_d1 = 1'b0, rst_d2 = 1'b0;
  logic          busy_prev = 1'b0;
  logic [WL-1:0] popped = '0;
  int            last_fall = -1000;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (cyc > 2) begin
        chk("pop_lat", fifo_re, cond_prev);
        chk("start_lat", tx_start, re_d2 && !rst_d2 && !rst_d1);
        if (fifo_re) begin
          n_re++;
          chk("pop_nonempty", !fifo_empty, 1);
          chk("gap", (cyc - last_fall) >= GAP + 2, 1);
          if (exp_q.size() > 0) popped = exp_q.pop_front();
        end
        if (tx_start) begin
          n_start++;
          chk("start_data", tx_data, popped);
        end
        if (active && busy_prev && !tx_busy) begin
          last_fall = cyc;
          chk("tx_hold", tx_data, popped);
        end
      end
      cond_prev = !rst && !active && en && !fifo_empty && !tx_busy;
      re_d2 = re_d1;  re_d1 = fifo_re;
      rst_d2 = rst_d1; rst_d1 = rst;
      busy_prev = tx_busy;
    end
  end

  task automatic drive_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag, input int target);
    int k = 0;
    while (!(sent_count == 16'(target) && !active) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk(tag, sent_count, target);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_re"},     fifo_re, 0);
    chk({tag, "_start"},  tx_start, 0);
    chk({tag, "_data"},   tx_data, 0);
    chk({tag, "_active"}, active, 0);
    chk({tag, "_sent"},   sent_count, 0);
    chk({tag, "_err"},    err, 0);
  endtask

  initial begin
    int re0, st0, k, n, tgt;

    // reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("rst");
    drive_cyc(); rst = 1'b0;

    // single word, busy held 10 cycles
    fix_d = 1; fix_b = 10;
    re0 = n_re; st0 = n_start;
    push(8'h61); en = 1'b1;
    wait_done("one_sent", 1);
    chk("one_re", n_re - re0, 1);
    chk("one_start", n_start - st0, 1);
    chk("one_empty", fifo_empty, 1);
    chk("one_idle", active, 0);
    drive_cyc(); en = 1'b0; fix_d = 0; fix_b = 0;

    // burst of five with gap
    st0 = n_start;
    for (int i = 0; i < 5; i++) push(8'h60 + 8'(i));
    en = 1'b1;
    wait_done("burst_sent", 6);
    chk("burst_start", n_start - st0, 5);
    drive_cyc(); en = 1'b0;

    // ACK timeout; err_clr in the timeout cycle must lose
    tx_mode = 1;
    push(8'hA5); en = 1'b1;
    k = 0;
    while (!tx_start && k < 200) begin @(negedge clk); k++; end
    chk("to_start", tx_start, 1);
    repeat (4) @(posedge clk);
    #1 err_clr = 1'b1;
    @(negedge clk);
    chk("to_pre_err", err, 0);
    chk("to_pre_act", active, 1);
    drive_cyc(); err_clr = 1'b0;
    @(negedge clk);
    chk("to_err", err, 1);
    chk("to_idle", active, 0);
    chk("to_sent", sent_count, 6);
    drive_cyc(); err_clr = 1'b1;
    drive_cyc(); err_clr = 1'b0;
    @(negedge clk);
    chk("to_clr", err, 0);
    en = 1'b0; tx_mode = 0;

    // tx_busy already high in IDLE blocks popping
    drive_cyc();
    busy_man = 1'b1;
    re0 = n_re;
    push(8'h11); push(8'h22); en = 1'b1;
    repeat (12) @(negedge clk);
    chk("busy_block", n_re - re0, 0);
    drive_cyc(); busy_man = 1'b0;
    wait_done("busy_sent", 8);
    chk("busy_re", n_re - re0, 2);
    drive_cyc(); en = 1'b0;

    // en dropped mid-transfer
    re0 = n_re;
    push(8'h31); push(8'h32); push(8'h33); en = 1'b1;
    k = 0;
    while (!(active && tx_busy) && k < 200) begin @(negedge clk); k++; end
    drive_cyc(); en = 1'b0;
    k = 0;
    while (active && k < 200) begin @(negedge clk); k++; end
    repeat (15) @(negedge clk);
    chk("endrop_sent", sent_count, 9);
    chk("endrop_re", n_re - re0, 1);
    drive_cyc(); en = 1'b1;
    wait_done("endrop_resume", 11);
    chk("endrop_re_all", n_re - re0, 3);
    drive_cyc(); en = 1'b0;

    // reset during LOAD drops the popped word
    push(8'h41); push(8'h42); push(8'h43); en = 1'b1;
    k = 0;
    while (!fifo_re && k < 200) begin @(negedge clk); k++; end
    chk("rl_pop", fifo_re, 1);
    drive_cyc(); rst = 1'b1;
    drive_cyc(); rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("rl");
    wait_done("rl_sent", 2);
    chk("rl_empty", fifo_empty, 1);
    drive_cyc(); en = 1'b0;

    // random words with random en
    n = int'($urandom_range(4, 8));
    tgt = 2 + n;
    for (int i = 0; i < n; i++) push(8'($urandom));
    k = 0;
    while (k < 3000) begin
      drive_cyc();
      en = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (sent_count == 16'(tgt) && !active && fifo_empty) break;
      k++;
    end
    chk("rand_sent", sent_count, tgt);
    chk("rand_empty", fifo_empty, 1);
    chk("rand_err", err, 0);
    drive_cyc(); en = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
